// File: rtl/pattern_shifter_if.sv
// rtl/pattern_shifter_if.sv - control and serial-output signal bundle for pattern_shifter
interface pattern_shifter_if #(
    parameter int WIDTH = 8
);
    localparam int LW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             load;
    logic [WIDTH-1:0] pattern;
    logic [LW-1:0]    len;
    logic             repeat_en;
    logic             step;
    logic             stop;

    logic             w;
    logic             w_valid;
    logic             busy;
    logic             done;
    logic             wrap;
    logic [LW-1:0]    bit_idx;
    logic [7:0]       sent_cnt;

    modport master (
        output load, pattern, len, repeat_en, step, stop,
        input  w, w_valid, busy, done, wrap, bit_idx, sent_cnt
    );

    modport slave (
        input  load, pattern, len, repeat_en, step, stop,
        output w, w_valid, busy, done, wrap, bit_idx, sent_cnt
    );
endinterface

// File: rtl/pattern_shifter.sv
// rtl/pattern_shifter.sv - serial pattern emitter feeding a sequence detector
module pattern_shifter #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              resetn,
    pattern_shifter_if.slave  bus
);
    localparam int LW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] pat_r;
    logic [LW-1:0]    len_r;
    logic             rep_r;

    logic             w_r;
    logic             w_valid_r;
    logic             busy_r;
    logic             done_r;
    logic             wrap_r;
    logic [LW-1:0]    idx_r;
    logic [7:0]       cnt_r;

    logic [LW-1:0]    next_idx;

    // index of the bit that follows the one currently on w
    assign next_idx = idx_r + LW'(1);

    // every output is a register so downstream sees no input-to-output path
    assign bus.w        = w_r;
    assign bus.w_valid  = w_valid_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.wrap     = wrap_r;
    assign bus.bit_idx  = idx_r;
    assign bus.sent_cnt = cnt_r;

    // IDLE/RUN/DONE sequencer; outputs are computed for the cycle after each edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            pat_r     <= '0;
            len_r     <= '0;
            rep_r     <= 1'b0;
            w_r       <= 1'b0;
            w_valid_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            wrap_r    <= 1'b0;
            idx_r     <= '0;
            cnt_r     <= '0;
        end else begin
            done_r <= 1'b0;
            wrap_r <= 1'b0;
            case (state)
                IDLE: begin
                    // load beats stop here; stop has no meaning outside RUN
                    if (bus.load) begin
                        pat_r     <= bus.pattern;
                        len_r     <= bus.len;
                        rep_r     <= bus.repeat_en;
                        idx_r     <= '0;
                        cnt_r     <= '0;
                        w_r       <= bus.pattern[0];
                        w_valid_r <= 1'b1;
                        busy_r    <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        // abort: the bit on w is dropped, index and count frozen
                        w_r       <= 1'b0;
                        w_valid_r <= 1'b0;
                        busy_r    <= 1'b0;
                        state     <= IDLE;
                    end else if (bus.step) begin
                        if (cnt_r != 8'hFF) begin
                            cnt_r <= cnt_r + 8'd1;
                        end
                        if (idx_r != len_r) begin
                            idx_r <= next_idx;
                            w_r   <= pat_r[next_idx];
                        end else if (rep_r) begin
                            idx_r  <= '0;
                            w_r    <= pat_r[0];
                            wrap_r <= 1'b1;
                        end else begin
                            // bit_idx stays on the last bit for status readback
                            w_r       <= 1'b0;
                            w_valid_r <= 1'b0;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    // single-cycle done pulse already registered; load is ignored here
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pattern_shifter.sv
// tb/tb_pattern_shifter.sv - scoreboard bench for pattern_shifter
module tb_pattern_shifter;
    localparam int WIDTH = 8;
    localparam int K_BIT  = 0;
    localparam int K_DONE = 1;
    localparam int K_WRAP = 2;

    typedef struct {
        int   kind;
        logic w;
        int   idx;
        int   cnt;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    pattern_shifter_if #(.WIDTH(WIDTH)) bus();
    pattern_shifter #(.WIDTH(WIDTH)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    // reference model: where we are in the pattern and how much has been consumed
    bit         m_active = 0;
    bit         m_in_done = 0;
    bit         m_wrap_now = 0;
    logic [7:0] m_pat = '0;
    int         m_len = 0;
    bit         m_rep = 0;
    int         m_pos = 0;
    int         m_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_in_done = 0; m_wrap_now = 0;
        m_pat = '0; m_len = 0; m_rep = 0; m_pos = 0; m_cnt = 0;
        sb.delete();
    endtask

    task automatic check_state();
        chk("busy", int'(bus.busy), int'(m_active));
        chk("w_valid", int'(bus.w_valid), int'(m_active));
        chk("w", int'(bus.w), m_active ? int'(m_pat[m_pos]) : 0);
        chk("bit_idx", int'(bus.bit_idx), m_pos);
        chk("sent_cnt", int'(bus.sent_cnt), m_cnt);
        chk("done", int'(bus.done), int'(m_in_done));
        chk("wrap", int'(bus.wrap), int'(m_wrap_now));
    endtask

    // check the current cycle, then drive inputs and advance the model to the next edge
    task automatic apply(input bit ld, input logic [7:0] p, input int l, input bit r,
                         input bit st, input bit sp);
        check_state();
        bus.load = ld; bus.pattern = p; bus.len = 3'(l); bus.repeat_en = r;
        bus.step = st; bus.stop = sp;
        m_wrap_now = 0;
        if (m_in_done) begin
            m_in_done = 0;
        end else if (!m_active) begin
            if (ld) begin
                m_active = 1; m_pat = p; m_len = l; m_rep = r; m_pos = 0; m_cnt = 0;
            end
        end else if (sp) begin
            m_active = 0;
        end else if (st) begin
            sb.push_back('{K_BIT, m_pat[m_pos], m_pos, m_cnt});
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            if (m_pos < m_len) begin
                m_pos++;
            end else if (m_rep) begin
                m_pos = 0;
                m_wrap_now = 1;
                sb.push_back('{K_WRAP, 1'b0, 0, 0});
            end else begin
                m_active = 0;
                m_in_done = 1;
                sb.push_back('{K_DONE, 1'b0, 0, 0});
            end
        end
    endtask

    task automatic cyc(input bit ld, input logic [7:0] p, input int l, input bit r,
                       input bit st, input bit sp);
        @(posedge clk); #1;
        apply(ld, p, l, r, st, sp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic pop_expect(input int kind, input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: DUT event with empty scoreboard at %0t", name, $time);
        end else begin
            e = sb.pop_front();
            chk({name, "_kind"}, e.kind, kind);
            if (kind == K_BIT && e.kind == K_BIT) begin
                chk("sb_w", int'(bus.w), int'(e.w));
                chk("sb_bit_idx", int'(bus.bit_idx), e.idx);
                chk("sb_sent_cnt", int'(bus.sent_cnt), e.cnt);
            end
        end
    endtask

    // monitor: pops one expectation per observed pulse or consumed bit
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.done) pop_expect(K_DONE, "sb_done");
            if (bus.wrap) pop_expect(K_WRAP, "sb_wrap");
            if (bus.w_valid && bus.step && !bus.stop) pop_expect(K_BIT, "sb_bit");
        end
    end

    initial begin
        bus.load = 0; bus.pattern = '0; bus.len = '0; bus.repeat_en = 0;
        bus.step = 0; bus.stop = 0;
        repeat (2) @(posedge clk);
        #1;
        check_state();

        // leave reset and load on the very first edge
        @(posedge clk); #1;
        resetn = 1;
        apply(1, 8'b1111_0000, 7, 0, 1, 0);
        for (int i = 0; i < 9; i++) cyc(1, 8'h3C, 5, 1, 1, 0);
        idle(2);

        // repeating 3-bit pattern, wrap after every third bit
        cyc(1, 8'b0000_0101, 2, 1, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 8'hFF, 7, 0, 1, 0);
        cyc(0, 8'h00, 0, 0, 0, 1);
        idle(1);

        // step toggling holds w and bit_idx
        cyc(1, 8'b1011_0110, 7, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 1, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 1, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 1);
        idle(1);

        // stop together with step at bit_idx 3
        cyc(1, 8'h5A, 7, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 0, 1, 0);
        cyc(0, 8'h00, 0, 0, 1, 1);
        idle(2);

        // asynchronous reset mid-emission at bit_idx 5
        cyc(1, 8'hC3, 7, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 8'h00, 0, 0, 1, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);
        #2;
        resetn = 0;
        #1;
        model_reset();
        check_state();
        @(posedge clk); #1;
        resetn = 1;
        apply(1, 8'h96, 7, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 0, 1, 0);
        cyc(0, 8'h00, 0, 0, 0, 1);

        // load and stop together in IDLE: load wins
        cyc(1, 8'h81, 3, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 8'h00, 0, 0, 1, 0);
        idle(1);

        // single-bit repeating pattern wraps on every step
        cyc(1, 8'h01, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 0, 0, 1, 0);
        cyc(0, 8'h00, 0, 0, 0, 1);

        // long repeat saturates sent_cnt; loads during RUN ignored
        cyc(1, 8'hA5, 7, 1, 0, 0);
        for (int i = 0; i < 300; i++) cyc(1, 8'($urandom), 3, 0, 1, 0);
        cyc(0, 8'h00, 0, 0, 0, 1);
        idle(2);

        // randomized transactions
        for (int t = 0; t < 40; t++) begin
            cyc(1, 8'($urandom), int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), 0, 0);
            for (int c = 0; c < 30; c++) begin
                cyc(($urandom_range(0, 4) == 0), 8'($urandom), int'($urandom_range(0, 7)),
                    bit'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 29) == 0));
            end
            if (m_active) cyc(0, 8'h00, 0, 0, 0, 1);
            idle(2);
        end

        idle(2);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
